// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between fetch_unit and memory.
// master: mem_addr/mem_rd out, mem_ready/mem_data in.
interface fetch_unit_if;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_ready;
  logic [15:0] mem_data;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_ready,
    input  mem_data
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_ready,
    output mem_data
  );
endinterface

// File: rtl/fetch_unit.sv
// LC-3 fetch sequencer: MAR<-PC, PC<-PC+1, MDR<-M[MAR], IR<-MDR.
// Ports: clk, reset (async low), start, PCIn, mem (master), ldPC,
// selPC, IR, busy, fetch_done, fetch_err. TIMEOUT=0 disables timeout.
module fetch_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] PCIn,
  fetch_unit_if.master mem,
  output logic        ldPC,
  output logic [1:0]  selPC,
  output logic [15:0] IR,
  output logic        busy,
  output logic        fetch_done,
  output logic        fetch_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic       TO_EN   = (TIMEOUT != 0);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] mar_q, mar_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rd_q, rd_d;
  logic        ld_q, ld_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    mar_d   = mar_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    ld_d    = ld_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        ld_d   = 1'b0;
        rd_d   = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        if (start) begin
          mar_d   = PCIn;
          ld_d    = 1'b1;
          rd_d    = 1'b1;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          cnt_d   = 8'd0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        ld_d = 1'b0;
        // ready takes priority over a timeout on the same edge
        if (mem.mem_ready) begin
          ir_d    = mem.mem_data;
          rd_d    = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (TO_EN && cnt_q == TO_LAST) begin
          rd_d    = 1'b0;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        ld_d    = 1'b0;
        rd_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ir_q    <= 16'h0000;
      mar_q   <= 16'h0000;
      cnt_q   <= 8'd0;
      rd_q    <= 1'b0;
      ld_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      mar_q   <= mar_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      ld_q    <= ld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mem.mem_addr = mar_q;
  assign mem.mem_rd   = rd_q;
  assign ldPC         = ld_q;
  assign selPC        = 2'b00;
  assign IR           = ir_q;
  assign busy         = busy_q;
  assign fetch_done   = done_q;
  assign fetch_err    = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit (TIMEOUT=4).
// Stimulus pushes expected completions; a negedge monitor pops them.
module tb_fetch_unit;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] pc_reg;
  logic [15:0] PCIn;
  logic        ldPC;
  logic [1:0]  selPC;
  logic [15:0] IR;
  logic        busy;
  logic        fetch_done;
  logic        fetch_err;
  logic [15:0] mem_data_v;
  logic        bb;

  fetch_unit_if mem ();

  fetch_unit #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .PCIn       (PCIn),
    .mem        (mem),
    .ldPC       (ldPC),
    .selPC      (selPC),
    .IR         (IR),
    .busy       (busy),
    .fetch_done (fetch_done),
    .fetch_err  (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register model: increments one edge after ldPC is seen
  always @(posedge clk) if (ldPC) pc_reg <= pc_reg + 16'd1;
  assign PCIn = pc_reg;

  assign mem.mem_data = bb ? (mem.mem_addr ^ 16'h5A00) : mem_data_v;

  typedef struct {
    bit          err;
    logic [15:0] ir;
    logic [15:0] addr;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] ir_model;
  bit          err_prev;
  bit          done_prev;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic pop_cmp(input bit is_err);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_underflow: got event err=%0d expected none",
               is_err);
      return;
    end
    e = sb.pop_front();
    chk("sb_kind", {31'd0, is_err}, {31'd0, e.err});
    chk("sb_ir", {16'd0, IR}, {16'd0, e.ir});
    chk("sb_addr", {16'd0, mem.mem_addr}, {16'd0, e.addr});
  endtask

  // Monitor: completions and timeouts are checked against the queue
  always @(negedge clk) begin
    if (fetch_done) begin
      pop_cmp(1'b0);
      chk("done_pulse", {31'd0, done_prev}, 32'd0);
      chk("done_noerr", {31'd0, fetch_err}, 32'd0);
    end
    if (fetch_err && !err_prev) begin
      pop_cmp(1'b1);
      chk("err_busy", {31'd0, busy}, 32'd0);
    end
    err_prev  = fetch_err;
    done_prev = fetch_done;
  end

  task automatic fetch(input logic [15:0] pc, input logic [15:0] data,
                       input int waits, input bit to);
    exp_t e;
    int   rd_cyc;
    int   ld_cyc;
    bit   ended;
    @(negedge clk);
    pc_reg     = pc;
    mem_data_v = data;
    start      = 1'b1;
    mem.mem_ready = 1'b0;
    e.err  = to;
    e.ir   = to ? ir_model : data;
    e.addr = pc;
    sb.push_back(e);
    if (!to) ir_model = data;
    @(negedge clk);
    start = 1'b0;
    chk("acc_ldpc", {31'd0, ldPC}, 32'd1);
    chk("acc_busy", {31'd0, busy}, 32'd1);
    chk("acc_err_clr", {31'd0, fetch_err}, 32'd0);
    chk("acc_addr", {16'd0, mem.mem_addr}, {16'd0, pc});
    rd_cyc = 0;
    ld_cyc = 0;
    ended  = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (!mem.mem_rd) begin
        ended = 1'b1;
        break;
      end
      rd_cyc++;
      if (ldPC) ld_cyc++;
      if (mem.mem_addr !== pc) begin
        chk("addr_stable", {16'd0, mem.mem_addr}, {16'd0, pc});
      end
      mem.mem_ready = !to && (k == waits + 1);
      @(negedge clk);
      mem.mem_ready = 1'b0;
    end
    chk("rd_ended", {31'd0, ended}, 32'd1);
    chk("rd_cycles", rd_cyc, to ? TO : waits + 1);
    chk("ldpc_once", ld_cyc, 32'd1);
    chk("pc_incr", {16'd0, pc_reg}, {16'd0, pc + 16'd1});
    if (to) begin
      chk("to_busy", {31'd0, busy}, 32'd0);
      chk("to_err", {31'd0, fetch_err}, 32'd1);
      chk("to_ir", {16'd0, IR}, {16'd0, ir_model});
    end else begin
      chk("dn_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("dn_idle", {31'd0, busy}, 32'd0);
      chk("dn_ir", {16'd0, IR}, {16'd0, data});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   ld_at[$];
    reset = 1'b0;
    start = 1'b0;
    bb    = 1'b0;
    pc_reg = 16'h3000;
    mem_data_v = 16'h0000;
    mem.mem_ready = 1'b0;
    ir_model = 16'h0000;
    err_prev = 1'b0;
    done_prev = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ir", {16'd0, IR}, 32'd0);
    chk("rst_addr", {16'd0, mem.mem_addr}, 32'd0);
    chk("rst_outs",
        {26'd0, mem.mem_rd, ldPC, busy, fetch_done, fetch_err, 1'b0},
        32'd0);
    chk("rst_selpc", {30'd0, selPC}, 32'd0);
    reset = 1'b1;

    fetch(16'h3000, 16'h1261, 0, 1'b0);
    fetch(16'h3001, 16'h5020, 3, 1'b0);
    fetch(16'h3050, 16'hDEAD, 0, 1'b1);
    repeat (3) @(negedge clk);
    chk("err_sticky", {31'd0, fetch_err}, 32'd1);
    fetch(16'h3060, 16'h0E05, 3, 1'b0);

    // back-to-back fetches with start held high
    @(negedge clk);
    bb = 1'b1;
    pc_reg = 16'h3000;
    mem.mem_ready = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e.err  = 1'b0;
      e.addr = 16'h3000 + 16'(i);
      e.ir   = e.addr ^ 16'h5A00;
      sb.push_back(e);
    end
    ir_model = 16'h3002 ^ 16'h5A00;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 7) start = 1'b0;
      if (ldPC) ld_at.push_back(k);
      if (k == 3) chk("bb_gap_idle", {31'd0, busy}, 32'd0);
    end
    chk("bb_count", ld_at.size(), 32'd3);
    if (ld_at.size() == 3) begin
      chk("bb_t0", ld_at[0], 32'd1);
      chk("bb_t1", ld_at[1], 32'd4);
      chk("bb_t2", ld_at[2], 32'd7);
    end
    chk("bb_pc", {16'd0, pc_reg}, 32'h3003);
    mem.mem_ready = 1'b0;
    bb = 1'b0;
    @(negedge clk);

    // reset in the middle of READ
    pc_reg = 16'h4000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mr_rd_hi", {31'd0, mem.mem_rd}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mr_rd_lo", {31'd0, mem.mem_rd}, 32'd0);
    chk("mr_ldpc", {31'd0, ldPC}, 32'd0);
    chk("mr_ir", {16'd0, IR}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    ir_model = 16'h0000;
    repeat (2) @(negedge clk);
    chk("mr_nodone", {31'd0, fetch_done}, 32'd0);
    reset = 1'b1;
    fetch(16'h4100, 16'h3F3F, 1, 1'b0);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    chk("end_selpc", {30'd0, selPC}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
